// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmit port: FSM encoding, status layout
// and the status-word packing helper.
package uart_tx_port_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int CMD_BIT     = 15;
  localparam int CMD_CLR_OVF = 0;

  function automatic logic [15:0] pack_status(
    input logic       empty,
    input logic       full,
    input logic       busy,
    input logic       ovf,
    input logic [3:0] cnt
  );
    logic [15:0] s;
    s                     = 16'h0000;
    s[ST_EMPTY]           = empty;
    s[ST_FULL]            = full;
    s[ST_BUSY]            = busy;
    s[ST_OVF]             = ovf;
    s[ST_CNT_LSB +: 4]    = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// Device-side bus between the I/O port block and the UART transmit port.
interface uart_tx_port_if;

  logic [15:0] wr_data;
  logic        wr_en;
  logic [15:0] status;
  logic        tx;

  modport master (output wr_data, output wr_en, input status, input tx);
  modport slave  (input wr_data, input wr_en, output status, output tx);

endinterface

// File: rtl/uart_tx_port_byte_fifo.sv
// Small synchronous byte FIFO; push while full and pop while empty are ignored,
// both judged on the count held before the edge.
module byte_fifo
  import uart_tx_port_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign push_ok_s = push && (count_r != CNT_FULL);
  assign pop_ok_s  = pop && (count_r != CNT_ZERO);

  assign dout  = mem_r[rd_ptr_r];
  assign empty = (count_r == CNT_ZERO);
  assign full  = (count_r == CNT_FULL);
  assign count = count_r;

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers and occupancy; pointer wrap relies on DEPTH being a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// 8N1 serial transmitter fed from the I/O port device-output word; returns a
// registered status word (empty/full/busy/overflow/count).
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_port_if.slave  bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_r;
  tx_state_e         state_next_s;
  logic [BAUD_W-1:0] baud_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              ovf_r;
  logic [15:0]       status_r;
  logic              tx_r;
  logic              tx_s;
  logic              baud_wrap_s;
  logic              pop_s;
  logic              push_s;
  logic              clr_ovf_s;
  logic [7:0]        fifo_dout_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [CNT_W-1:0]  fifo_count_s;

  assign push_s      = bus.wr_en && !bus.wr_data[CMD_BIT];
  assign clr_ovf_s   = bus.wr_en && bus.wr_data[CMD_BIT] && bus.wr_data[CMD_CLR_OVF];
  assign baud_wrap_s = (baud_r == BAUD_LAST);
  assign bus.tx      = tx_r;
  assign bus.status  = status_r;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.wr_data[7:0]),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state decode and FIFO pop request
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (baud_wrap_s) begin
          state_next_s = DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (baud_wrap_s && (bit_idx_r == 3'd7)) begin
          state_next_s = STOP;
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (baud_wrap_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
        pop_s        = 1'b0;
      end
    endcase
  end

  // line level implied by the current state; registered below so tx lags by one cycle
  always_comb begin
    tx_s = 1'b1;
    case (state_r)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_r[0];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // registered serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_r <= 1'b1;
    end else begin
      tx_r <= tx_s;
    end
  end

  // baud counter, bit index and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_r    <= BAUD_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          baud_r    <= BAUD_ZERO;
          bit_idx_r <= 3'd0;
          if (pop_s) begin
            shift_r <= fifo_dout_s;
          end
        end
        START: begin
          baud_r    <= baud_wrap_s ? BAUD_ZERO : baud_r + BAUD_ONE;
          bit_idx_r <= 3'd0;
        end
        DATA: begin
          baud_r <= baud_wrap_s ? BAUD_ZERO : baud_r + BAUD_ONE;
          if (baud_wrap_s) begin
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
          end
        end
        STOP: begin
          baud_r <= baud_wrap_s ? BAUD_ZERO : baud_r + BAUD_ONE;
        end
        default: begin
          baud_r    <= BAUD_ZERO;
          bit_idx_r <= 3'd0;
        end
      endcase
    end
  end

  // sticky overflow: a data write that meets a full FIFO is lost, even if a pop coincides
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (push_s && fifo_full_s) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // status word, one cycle behind the state it reports
  always_ff @(posedge clk) begin
    if (reset) begin
      status_r <= pack_status(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    end else begin
      status_r <= pack_status(fifo_empty_s, fifo_full_s, (state_r != IDLE),
                              ovf_r, 4'(fifo_count_s));
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_port;

  logic clk;
  logic reset;
  int   total_cnt;
  int   bad_cnt;
  int   framing_err;
  logic [7:0] rx_q [$];

  uart_tx_port_if bus_if ();

  uart_tx_port #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_word(input logic [15:0] w);
    bus_if.wr_data = w;
    bus_if.wr_en   = 1'b1;
    @(negedge clk);
    bus_if.wr_en   = 1'b0;
  endtask

  // samples the current cycle as the first of the start bit
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] exp_bits;
    logic [3:0] samp;
    exp_bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int s = 0; s < 4; s++) begin
        samp[s] = bus_if.tx;
        @(negedge clk);
      end
      check_val($sformatf("%s_bit%0d", tag, k), 32'(samp), 32'({4{exp_bits[k]}}));
    end
  endtask

  task automatic wait_tx_low(input string tag, input int budget);
    int n;
    n = 0;
    while (bus_if.tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(bus_if.tx), 32'h0);
  endtask

  task automatic no_edges(input string tag, input int cycles);
    logic prev;
    int   edges;
    prev  = bus_if.tx;
    edges = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_if.tx !== prev) edges++;
      prev = bus_if.tx;
    end
    check_val(tag, 32'(edges), 32'h0);
  endtask

  // independent receiver: mid-bit sampling, frames hit by reset are discarded
  initial begin : rx_monitor
    logic [9:0] fr;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (bus_if.tx === 1'b0 && reset === 1'b0) begin
        fr      = 10'h000;
        aborted = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (reset !== 1'b0) aborted = 1'b1;
          if ((i % 4) == 2) fr[i / 4] = bus_if.tx;
        end
        if (!aborted) begin
          if (fr[0] == 1'b0 && fr[9] == 1'b1) rx_q.push_back(fr[8:1]);
          else framing_err++;
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    total_cnt      = 0;
    bad_cnt        = 0;
    framing_err    = 0;
    reset          = 1'b1;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = 16'h00FF;

    // reset held two cycles with a write that must be ignored
    tick();
    tick();
    reset        = 1'b0;
    bus_if.wr_en = 1'b0;
    check_val("rst_tx", 32'(bus_if.tx), 32'h1);
    check_val("rst_status", 32'(bus_if.status), 32'h0001);
    no_edges("rst_quiet", 50);
    check_val("rst_status_late", 32'(bus_if.status), 32'h0001);
    check_val("rst_no_rx", 32'(rx_q.size()), 32'h0);

    // single byte: start bit appears two edges after the write edge
    write_word(16'h00A5);
    check_val("lat_e0", 32'(bus_if.tx), 32'h1);
    tick();
    check_val("lat_e1", 32'(bus_if.tx), 32'h1);
    tick();
    check_val("lat_e2", 32'(bus_if.tx), 32'h0);
    check_val("busy_in_frame", 32'(bus_if.status[2]), 32'h1);
    check_frame("a5", 8'hA5);
    check_val("idle_status", 32'(bus_if.status), 32'h0001);
    check_val("a5_rx_cnt", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() > 0) check_val("a5_rx", 32'(rx_q.pop_front()), 32'hA5);

    // back-to-back frames with one idle cycle between
    write_word(16'h0055);
    write_word(16'h000F);
    wait_tx_low("b2b_start1", 10);
    check_frame("b2b_55", 8'h55);
    check_val("b2b_gap", 32'(bus_if.tx), 32'h1);
    tick();
    check_val("b2b_start2", 32'(bus_if.tx), 32'h0);
    check_frame("b2b_0f", 8'h0F);
    check_val("b2b_rx_cnt", 32'(rx_q.size()), 32'h2);
    if (rx_q.size() > 1) begin
      check_val("b2b_rx0", 32'(rx_q.pop_front()), 32'h55);
      check_val("b2b_rx1", 32'(rx_q.pop_front()), 32'h0F);
    end

    // overflow: six writes, the sixth meets a full FIFO
    for (int i = 1; i <= 6; i++) write_word(16'(i));
    tick();
    check_val("ovf_status", 32'(bus_if.status), 32'h004E);
    n = 0;
    while (rx_q.size() < 5 && n < 400) begin
      tick();
      n++;
    end
    check_val("ovf_rx_cnt", 32'(rx_q.size()), 32'h5);
    repeat (3) tick();
    check_val("ovf_sticky", 32'(bus_if.status), 32'h0009);
    check_val("ovf_rx_cnt_final", 32'(rx_q.size()), 32'h5);
    for (int i = 1; i <= 5; i++) begin
      if (rx_q.size() > 0) check_val($sformatf("ovf_rx%0d", i), 32'(rx_q.pop_front()), 32'(i));
    end

    // overflow clear command: no enqueue, no frame
    write_word(16'h8001);
    tick();
    check_val("clr_status", 32'(bus_if.status), 32'h0001);
    no_edges("clr_no_frame", 20);
    check_val("clr_no_rx", 32'(rx_q.size()), 32'h0);

    // reset in the middle of a frame with two bytes queued
    write_word(16'h00A5);
    write_word(16'h0011);
    write_word(16'h0022);
    wait_tx_low("mid_start", 8);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    check_val("mid_rst_tx", 32'(bus_if.tx), 32'h1);
    check_val("mid_rst_status", 32'(bus_if.status), 32'h0001);
    tick();
    reset = 1'b0;
    no_edges("mid_rst_quiet", 100);
    check_val("mid_rst_no_rx", 32'(rx_q.size()), 32'h0);
    check_val("mid_rst_status_late", 32'(bus_if.status), 32'h0001);
    check_val("framing", 32'(framing_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Serial transmit peripheral sitting directly downstream of the I/O port block.
- Consumes the 16-bit word that block drives to the device side, plus a write strobe.
- Queues the low byte in a small FIFO and shifts it out as 8N1 serial on `tx`.
- Returns a 16-bit status word the I/O port block reads back as its device-input value.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per serial bit. Minimum 2. 868 gives 115200 baud at 100 MHz.
- FIFO_DEPTH, 4: byte FIFO entries. Must be a power of 2, range 2..8.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_data  input  16  word from the I/O port device-output side.
- wr_en  input  1  one-cycle write strobe qualifying wr_data.
- status  output  16  status word to the I/O port device-input side.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (synchronous, active-high):
  - tx=1, FSM=IDLE, FIFO emptied, overflow=0, baud and bit counters=0.
  - status reads 16'h0001 from the cycle after reset is sampled.
- Write decode, on a clk edge where wr_en=1:
  - wr_data[15]=1: command write, not enqueued. wr_data[0]=1 clears the overflow flag; other bits ignored.
  - wr_data[15]=0: enqueue wr_data[7:0]; wr_data[14:8] ignored.
- Full FIFO:
  - Full is judged on the pre-edge count.
  - A data write while full is dropped and sets sticky overflow=1.
  - This holds even if the FSM pops in the same cycle.
- Simultaneous push and pop (not full): both take effect; count unchanged.
- Status word, registered and valid one cycle after the state change:
  - [0] fifo_empty, [1] fifo_full, [2] tx_busy (FSM != IDLE), [3] overflow, [7:4] fifo count.
  - [15:8] = 0.
- FSM states, with tx driven from a registered output:
  - IDLE: tx=1. If FIFO not empty: pop head into the shift register, baud counter=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP. LSB first.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency:
  - Data write on edge E0 with FIFO empty and FSM idle: pop on E1, tx low from E2.
  - Frame = 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: exactly one IDLE cycle (tx=1) between the stop bit and the next start bit.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Sized to clog2(CLKS_PER_BIT).
  - The bit advances on the wrap cycle.
- Reset mid-frame:
  - Frame aborted; tx=1 on the next cycle.
  - Queued bytes discarded; no partial resume.
- wr_en during reset: ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Status bit positions: ST_EMPTY=0, ST_FULL=1, ST_BUSY=2, ST_OVF=3, ST_CNT_LSB=4.
  - Command bit CMD_BIT=15.
- One sub-module, `byte_fifo`:
  - Synchronous FIFO parameterised by depth.
  - Ports: push, pop, din[7:0], dout[7:0], empty, full, count.
  - Same clk and reset.
- The FSM, baud counter and status register stay in uart_tx_port.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset: hold reset 2 cycles -> tx=1, status=16'h0001, no edge on tx for 50 cycles.
- Single byte: write 16'h00A5 at E0 -> tx low from E2; 40-cycle frame, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1. status[2]=1 during the frame, 0 after.
- Back-to-back: write 0x55 and 0x0F on consecutive cycles -> two frames separated by exactly one high cycle; second frame bits 0,1,1,1,1,0,0,0,0,1.
- Overflow: data writes on 6 consecutive cycles (0x01..0x06) -> 0x06 dropped; status[1]=1 and status[3]=1 after E5; 0x01..0x05 transmitted in order; overflow stays set.
- Overflow clear: write 16'h8001 -> status[3]=0 next cycle; FIFO count unchanged; no frame started.
- Mid-frame reset: assert reset at cycle 15 of a 0xA5 frame with 2 bytes queued -> tx=1 next cycle, status=16'h0001, no further frames.
